// File: rtl/instr_issuer.sv
// Serial instruction loader: deserializes MSB-first words into a small FIFO
// and issues them on INSTRUCTION/write_en with a minimum spacing of GAP cycles.
module instr_issuer #(
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 4,
  parameter int GAP     = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               SDI,
  input  logic               SVALID,
  input  logic               SCLR,
  input  logic               HOLD,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               write_en,
  output logic               FULL,
  output logic               EMPTY,
  output logic               OVERFLOW,
  output logic [7:0]         ISSUE_COUNT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(INSTR_W);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_nxt;
  logic [GW-1:0]      gap_q, gap_nxt;
  logic [INSTR_W-2:0] shreg;
  logic [BW-1:0]      bitcnt;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_nxt;
  logic [INSTR_W-1:0] new_word;
  logic               word_done, push_ok, pop;

  // A completed word may enter a full FIFO only when the head leaves on the same edge.
  always_comb begin
    new_word  = {shreg, SDI};
    word_done = SVALID && !SCLR && (bitcnt == BW'(INSTR_W - 1));
    push_ok   = word_done && ((count < CW'(DEPTH)) || pop);
    count_nxt = count + CW'(push_ok) - CW'(pop);
  end

  always_comb begin
    state_nxt = state_q;
    gap_nxt   = gap_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count != '0) && !HOLD) begin
          pop = 1'b1;
          if (GAP > 1) begin
            state_nxt = WAIT;
            gap_nxt   = GW'(GAP - 1);
          end
        end
      end
      WAIT: begin
        if (gap_q == GW'(1)) state_nxt = IDLE;
        else                 gap_nxt   = gap_q - GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_nxt;
      gap_q   <= gap_nxt;
    end
  end

  // A finished word always restarts the bit counter, even when it is dropped.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (SCLR) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (SVALID) begin
      shreg  <= new_word[INSTR_W-2:0];
      bitcnt <= word_done ? '0 : bitcnt + BW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= new_word;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      FULL     <= 1'b0;
      EMPTY    <= 1'b1;
      OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      FULL  <= (count_nxt == CW'(DEPTH));
      EMPTY <= (count_nxt == '0);
      if (word_done && !push_ok) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      INSTRUCTION <= '0;
      write_en    <= 1'b0;
      ISSUE_COUNT <= '0;
    end else begin
      write_en <= pop;
      if (pop) begin
        INSTRUCTION <= mem[rd_ptr];
        ISSUE_COUNT <= ISSUE_COUNT + 8'd1;
      end
    end
  end

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
Serial instruction loader and issuer that feeds the cpu instruction port.
- Deserializes 9-bit instructions from a single-bit serial pin (MSB first) and buffers them in a small FIFO.
- Presents each buffered instruction on INSTRUCTION with a one-cycle write_en strobe, with a programmable minimum issue spacing.
- Sits between the tile input pins and the cpu's INSTRUCTION/write_en inputs; it is the producing end of that interface.

Parameters:
INSTR_W, 9, instruction width in bits; matches the cpu INSTRUCTION port.
DEPTH, 4, FIFO entries; power of two, at least 2.
GAP, 2, minimum cycles between consecutive write_en assertions; at least 1.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RESET_N  input  1  asynchronous, active-low reset.
SDI  input  1  serial instruction data, MSB first.
SVALID  input  1  SDI is sampled on this cycle's rising edge.
SCLR  input  1  synchronous abort of the partially received word.
HOLD  input  1  suppresses new issues while high.
INSTRUCTION  output  INSTR_W  last issued instruction; registered.
write_en  output  1  one-cycle issue strobe; registered.
FULL  output  1  FIFO holds DEPTH entries.
EMPTY  output  1  FIFO holds 0 entries.
OVERFLOW  output  1  sticky; a completed word was dropped.
ISSUE_COUNT  output  8  number of issues, modulo 256.

Behaviour:
Reset:
- While RESET_N=0, immediately and asynchronously: INSTRUCTION=0, write_en=0, FULL=0, EMPTY=1, OVERFLOW=0, ISSUE_COUNT=0.
- Shift register, bit counter, FIFO pointers and occupancy count are cleared; FSM goes to IDLE.
- Reset mid-word or mid-gap discards all partial and buffered data.

Deserializer:
- On an edge with SVALID=1: shreg <= {shreg[INSTR_W-2:0], SDI}, bitcnt increments.
- When the INSTR_W-th bit is sampled (bitcnt==INSTR_W-1), the word {shreg[INSTR_W-2:0], SDI} is pushed on that same edge and bitcnt returns to 0.
- SCLR=1 clears bitcnt and shreg and overrides SVALID in the same cycle. SCLR does not affect the FIFO.

FIFO:
- Push is accepted if occupancy<DEPTH, or if a pop happens on the same edge. In that case occupancy is unchanged and no data is lost.
- A rejected push sets OVERFLOW, discards the word and still resets bitcnt.
- OVERFLOW clears only on reset.
- FULL and EMPTY are registered and reflect occupancy after each edge.

Issue FSM (states IDLE, WAIT):
- IDLE: at an edge with FIFO non-empty (pre-edge) and HOLD=0:
  - pop the head; INSTRUCTION <= head; write_en <= 1; ISSUE_COUNT increments (wraps 255 to 0).
  - If GAP>1: gap_cnt <= GAP-1 and go to WAIT. Otherwise stay in IDLE.
- IDLE with no issue: write_en <= 0.
- WAIT: write_en <= 0. If gap_cnt==1, go to IDLE; otherwise decrement gap_cnt.
  - HOLD does not stall the countdown; it is sampled only in IDLE.
- Result: consecutive write_en pulses are exactly GAP cycles apart when the FIFO stays non-empty and HOLD=0.
- INSTRUCTION holds its value between issues.

Latency and arbitration:
- The earliest write_en is the edge after the edge that pushed a word into an empty FIFO; a word is never issued on its own push edge.
- Simultaneous push and pop: the pop takes the old head; FIFO order is preserved.

Test Plan:
- GAP=2: shift 9'h1A5 MSB first, one bit per cycle -> FIFO push at the 9th-bit edge; write_en=1 for exactly one cycle starting the next edge; INSTRUCTION=9'h1A5; ISSUE_COUNT=1; EMPTY=1 afterwards.
- HOLD=1: shift 5 words 9'h001..9'h005 -> FULL=1 after the 4th word; 5th dropped; OVERFLOW=1. Release HOLD -> 4 pulses spaced 2 cycles carrying 001, 002, 003, 004. OVERFLOW stays 1.
- Shift 5 bits, pulse SCLR, then shift 9'h0FF -> a single issue of 9'h0FF, with no corrupted prefix.
- FIFO full, HOLD=0, 9th bit of 9'h155 lands on the issue/pop edge -> push accepted, OVERFLOW=0, FULL remains 1, 9'h155 is issued last.
- Assert RESET_N=0 mid-word and during WAIT -> all outputs return to reset values at once. A fresh word 9'h0A0 then issues normally with ISSUE_COUNT=1.
- GAP=1: 256 back-to-back issues -> write_en high continuously while fed; ISSUE_COUNT wraps to 0.
